// File: rtl/ro_trng_core.sv
// ro_trng_core: ring-oscillator entropy source with staged ring enables,
// warm-up delay, optional von Neumann debiasing, repetition-count health test
// and WORD_W-bit word packing behind a valid/ready output.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   enable_i        run request (level)
//   test_mode_i     use test_bit_i/test_valid_i instead of the rings
//   test_bit_i      injected raw bit, qualified by test_valid_i
//   debias_en_i     enable von Neumann corrector
//   rdy_i           consumer ready
//   data_o/valid_o  packed output word / word pending
//   enable_o        last stage of the enable chain (cascade)
//   busy_o          FSM in RAMP or WARMUP
//   health_fail_o   sticky repetition-count failure

// One ring: STAGES inverting latches closed through a sampling flop, so the
// only loop in the ring passes through a register.
module ro_trng_ring #(
  parameter int STAGES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic [STAGES-1:0] stage_en,
  output logic              samp
);
  logic [STAGES-1:0] lat;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic pred;
    logic q;
    if (k == 0) begin : g_head
      assign pred = samp;
    end else begin : g_body
      assign pred = lat[k-1];
    end
    // Latch clears whenever the run request drops.
    always_latch begin
      if (!rst || !enable_i) q <= 1'b0;
      else if (stage_en[k])  q <= ~pred;
    end
    assign lat[k] = q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) samp <= 1'b0;
    else      samp <= lat[STAGES-1];
  end
endmodule

module ro_trng_core #(
  parameter int NUM_RINGS     = 3,
  parameter int BASE_STAGES   = 5,
  parameter int WORD_W        = 8,
  parameter int REP_LIMIT     = 16,
  parameter int WARMUP_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              test_mode_i,
  input  logic              test_bit_i,
  input  logic              test_valid_i,
  input  logic              debias_en_i,
  input  logic              rdy_i,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  output logic              enable_o,
  output logic              busy_o,
  output logic              health_fail_o
);
  localparam int L    = NUM_RINGS*BASE_STAGES + NUM_RINGS*(NUM_RINGS-1);
  localparam int CW   = $clog2(WORD_W+1);
  localparam int WU_W = $clog2(WARMUP_CYCLES+1);

  typedef enum logic [2:0] {S_IDLE, S_RAMP, S_WARMUP, S_RUN, S_FAIL} state_t;
  state_t state_q, state_d;

  logic [L-1:0]         en_chain;
  logic [NUM_RINGS-1:0] samp;
  logic [WU_W-1:0]      wu_cnt;
  logic [7:0]           rep_cnt, rep_next;
  logic                 rep_prev, pair_have, pair_bit;
  logic [WORD_W-1:0]    coll, word, top_bit;
  logic [CW-1:0]        cnt;
  logic                 raw_vld, raw_bit, rep_trip, acc, acc_bit;
  logic                 word_done, out_free, xfer;

  // Enable chain threads ring 0 first, then ring 1, ...; flushed in FAIL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) en_chain <= '0;
    else      en_chain <= {en_chain[L-2:0], (state_q == S_FAIL) ? 1'b0 : enable_i};
  end
  assign enable_o = en_chain[L-1];

  for (genvar i = 0; i < NUM_RINGS; i++) begin : g_ring
    localparam int STG = BASE_STAGES + 2*i;
    localparam int OFF = i*BASE_STAGES + i*(i-1);
    ro_trng_ring #(.STAGES(STG)) u_ring (
      .clk      (clk),
      .rst      (rst),
      .enable_i (enable_i),
      .stage_en (en_chain[OFF +: STG]),
      .samp     (samp[i])
    );
  end

  // FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable_i) state_d = S_RAMP;
      S_RAMP:   if (!enable_i) state_d = S_IDLE;
                else if (enable_o) state_d = S_WARMUP;
      S_WARMUP: if (!enable_i) state_d = S_IDLE;
                else if (wu_cnt == '0) state_d = S_RUN;
      S_RUN:    if (!enable_i) state_d = S_IDLE;
                else if (rep_trip) state_d = S_FAIL;
      S_FAIL:   if (!enable_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q == S_RAMP) || (state_q == S_WARMUP);

  // Raw bit source, health test and debias decision
  always_comb begin
    raw_vld  = (state_q == S_RUN) && enable_i && (!test_mode_i || test_valid_i);
    raw_bit  = test_mode_i ? test_bit_i : ^samp;
    // rep_cnt == 0 marks "no previous bit since entering RUN".
    rep_next = (rep_cnt == 8'd0 || raw_bit != rep_prev) ? 8'd1 : rep_cnt + 8'd1;
    rep_trip = raw_vld && (rep_next == 8'(REP_LIMIT));
    if (debias_en_i) begin
      acc     = raw_vld && pair_have && (pair_bit != raw_bit);
      acc_bit = pair_bit;
    end else begin
      acc     = raw_vld;
      acc_bit = raw_bit;
    end
    // A failure in the same cycle suppresses the bit (failure wins).
    acc = acc && !rep_trip;
    top_bit = '0;
    top_bit[WORD_W-1] = acc_bit;
    // A full, stalled collector keeps its word and drops new bits.
    word      = (cnt == CW'(WORD_W)) ? coll : ((coll >> 1) | top_bit);
    word_done = (cnt == CW'(WORD_W)) || (acc && cnt == CW'(WORD_W-1));
    xfer      = valid_o && rdy_i;
    out_free  = !valid_o || rdy_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wu_cnt        <= '0;
      rep_cnt       <= '0;
      rep_prev      <= 1'b0;
      pair_have     <= 1'b0;
      pair_bit      <= 1'b0;
      coll          <= '0;
      cnt           <= '0;
      data_o        <= '0;
      valid_o       <= 1'b0;
      health_fail_o <= 1'b0;
    end else begin
      if (state_q == S_RAMP && state_d == S_WARMUP) wu_cnt <= WU_W'(WARMUP_CYCLES-1);
      else if (state_q == S_WARMUP && wu_cnt != '0) wu_cnt <= wu_cnt - 1'b1;

      if (state_q == S_FAIL || rep_trip) begin
        valid_o   <= 1'b0;
        data_o    <= '0;
        coll      <= '0;
        cnt       <= '0;
        pair_have <= 1'b0;
        rep_cnt   <= '0;
        if (rep_trip)       health_fail_o <= 1'b1;
        else if (!enable_i) health_fail_o <= 1'b0;
      end else if (!enable_i) begin
        // Leaving for IDLE: drop partial state, keep a pending output word.
        coll      <= '0;
        cnt       <= '0;
        pair_have <= 1'b0;
        rep_cnt   <= '0;
        if (xfer) valid_o <= 1'b0;
      end else begin
        if (xfer) valid_o <= 1'b0;
        if (raw_vld) begin
          rep_cnt   <= rep_next;
          rep_prev  <= raw_bit;
          pair_have <= debias_en_i ? !pair_have : 1'b0;
          pair_bit  <= raw_bit;
        end
        if (word_done) begin
          if (out_free) begin
            data_o  <= word;
            valid_o <= 1'b1;
            coll    <= '0;
            cnt     <= '0;
          end else begin
            coll <= word;
            cnt  <= CW'(WORD_W);
          end
        end else if (acc) begin
          coll <= word;
          cnt  <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ro_trng_core.sv
// Directed bench for ro_trng_core with default parameters (L = 21).
module tb_ro_trng_core;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable_i = 1'b0, test_mode_i = 1'b0, test_bit_i = 1'b0;
  logic         test_valid_i = 1'b0, debias_en_i = 1'b0, rdy_i = 1'b0;
  logic [W-1:0] data_o;
  logic         valid_o, enable_o, busy_o, health_fail_o;
  int           n_chk = 0, n_err = 0;
  int           t_en, t_busy, n_fall;

  ro_trng_core dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .test_mode_i   (test_mode_i),
    .test_bit_i    (test_bit_i),
    .test_valid_i  (test_valid_i),
    .debias_en_i   (debias_en_i),
    .rdy_i         (rdy_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .enable_o      (enable_o),
    .busy_o        (busy_o),
    .health_fail_o (health_fail_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    test_bit_i   = b;
    test_valid_i = 1'b1;
    tick();
    test_valid_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  // Edges until enable_o first seen, and number of samples with busy_o high.
  task automatic ramp(output int te, output int tb);
    te = -1;
    tb = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (enable_o && te < 0) te = k;
      if (busy_o) tb++;
      else if (k > 1) break;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  data_o, 0);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_en"},    enable_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_hf"},    health_fail_o, 0);
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      enable_i     = 1'($urandom);
      test_mode_i  = 1'($urandom);
      test_bit_i   = 1'($urandom);
      test_valid_i = 1'($urandom);
      debias_en_i  = 1'($urandom);
      rdy_i        = 1'($urandom);
      #7;
    end
    chk_all_zero("rst");

    enable_i = 0; test_mode_i = 1; test_bit_i = 0; test_valid_i = 0;
    debias_en_i = 0; rdy_i = 1;
    tick();
    rst = 1'b1;
    tick();

    // Ramp + warm-up
    enable_i = 1'b1;
    ramp(t_en, t_busy);
    chk("en_latency", t_en, 21);
    chk("busy_len", t_busy, 85);
    chk("run_en", enable_o, 1);
    chk("run_hf", health_fail_o, 0);

    // Plain word 1,0,1,1,0,0,1,0 -> 0x4D
    begin
      logic [7:0] v;
      v = 8'b0100_1101;
      for (int i = 0; i < 8; i++) begin
        send_bit(v[i]);
        if (i == 6) chk("w1_pre", valid_o, 0);
      end
    end
    chk("w1_valid", valid_o, 1);
    chk("w1_data", data_o, 8'h4D);
    tick();
    chk("w1_drop", valid_o, 0);

    // Debias: (10,01,00,11) x4 -> 0x55
    debias_en_i = 1'b1;
    rdy_i = 1'b0;
    for (int r = 0; r < 4; r++) begin
      send_bit(1); send_bit(0);
      send_bit(0); send_bit(1);
      send_bit(0); send_bit(0);
      send_bit(1); send_bit(1);
    end
    chk("db_valid", valid_o, 1);
    chk("db_data", data_o, 8'h55);
    chk("db_hf", health_fail_o, 0);
    rdy_i = 1'b1;
    tick();
    chk("db_drop", valid_o, 0);
    debias_en_i = 1'b0;

    // Backpressure: A5 to output, 3C held, FF dropped
    rdy_i = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(8'hFF);
    chk("bp_valid", valid_o, 1);
    chk("bp_hold", data_o, 8'hA5);
    rdy_i = 1'b1;
    tick();
    chk("bp_next_valid", valid_o, 1);
    chk("bp_next_data", data_o, 8'h3C);
    tick();
    chk("bp_ff_dropped", valid_o, 0);

    // Health: 0 then 16 ones trips the repetition test
    rdy_i = 1'b0;
    send_bit(0);
    for (int i = 0; i < 15; i++) send_bit(1);
    chk("rep_pre_hf", health_fail_o, 0);
    chk("rep_pre_valid", valid_o, 1);
    chk("rep_pre_data", data_o, 8'hFE);
    send_bit(1);
    chk("rep_hf", health_fail_o, 1);
    chk("rep_valid", valid_o, 0);
    n_fall = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (!enable_o) begin
        n_fall = k;
        break;
      end
    end
    chk("en_fall_in_L", (n_fall >= 1 && n_fall <= 21), 1);
    chk("fail_sticky", health_fail_o, 1);
    enable_i = 1'b0;
    tick();
    chk("hf_clear", health_fail_o, 0);
    chk("idle_busy", busy_o, 0);
    enable_i = 1'b1;
    tick();
    chk("idle_to_ramp", busy_o, 1);

    // Back to RUN, leave a word pending, then async reset
    ramp(t_en, t_busy);
    chk("rerun_busy", busy_o, 0);
    send_byte(8'h5A);
    chk("pend_valid", valid_o, 1);
    chk("pend_data", data_o, 8'h5A);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("arst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
